// File: rtl/node_invoker_if.sv
// node_invoker_if: host request/response stream and child ST/RD link seen by node_invoker
interface node_invoker_if #(parameter int WIDTH = 16);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_to;
    logic             busy;
    logic             ch_st;
    logic             ch_rd;
    logic [WIDTH-1:0] ch_res;
    logic [WIDTH-1:0] ch_in0;
    logic [WIDTH-1:0] ch_in1;
    modport master (
        output req_valid, req_a, req_b, rsp_ready, ch_rd, ch_res,
        input  req_ready, rsp_valid, rsp_data, rsp_to, busy, ch_st, ch_in0, ch_in1
    );
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, ch_rd, ch_res,
        output req_ready, rsp_valid, rsp_data, rsp_to, busy, ch_st, ch_in0, ch_in1
    );
endinterface

// File: rtl/node_invoker.sv
// node_invoker: queues argument pairs and runs one child node job at a time over the ST/RD handshake,
// returning each result (or a timeout marker) on a valid/ready response port.
module node_invoker #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1000
) (
    input logic           clk,
    input logic           rst_n,
    node_invoker_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {IDLE, LAUNCH, RUN, HOLD, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mem_a [DEPTH];
    logic [WIDTH-1:0] mem_b [DEPTH];
    logic [PW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             st_q, st_d, rv_q, rv_d, to_q, to_d, drain_q, drain_d;
    logic [WIDTH-1:0] in0_q, in0_d, in1_q, in1_d, data_q, data_d;
    logic             push, pop, done;

    assign bus.req_ready = cnt_q != CW'(DEPTH);
    assign push          = bus.req_valid && bus.req_ready;
    assign cnt_d         = cnt_q + CW'(push) - CW'(pop);
    // LAUNCH completes when the child drops RD, RUN when it raises RD again
    assign done          = (state_q == LAUNCH) ? !bus.ch_rd : bus.ch_rd;
    assign bus.rsp_valid = rv_q;
    assign bus.rsp_data  = data_q;
    assign bus.rsp_to    = to_q;
    assign bus.ch_st     = st_q;
    assign bus.ch_in0    = in0_q;
    assign bus.ch_in1    = in1_q;
    assign bus.busy      = (state_q != IDLE) || (cnt_q != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_q] <= bus.req_a;
            mem_b[wr_q] <= bus.req_b;
        end
    end

    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        in0_d   = in0_q;
        in1_d   = in1_q;
        timer_d = timer_q;
        rv_d    = rv_q;
        data_d  = data_q;
        to_d    = to_q;
        drain_d = drain_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: if (cnt_q != '0 && bus.ch_rd) begin
                pop     = 1'b1;
                in0_d   = mem_a[rd_q];
                in1_d   = mem_b[rd_q];
                st_d    = 1'b1;
                timer_d = '0;
                state_d = LAUNCH;
            end
            LAUNCH, RUN: begin
                timer_d = timer_q + TW'(1);
                if (done && state_q == LAUNCH) begin
                    st_d    = 1'b0;
                    state_d = RUN;
                end else if (done) begin
                    data_d  = bus.ch_res;
                    to_d    = 1'b0;
                    rv_d    = 1'b1;
                    state_d = HOLD;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    st_d    = 1'b0;
                    data_d  = '0;
                    to_d    = 1'b1;
                    rv_d    = 1'b1;
                    drain_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: if (bus.rsp_ready) begin
                rv_d    = 1'b0;
                state_d = drain_q ? DRAIN : IDLE;
            end
            DRAIN: if (bus.ch_rd) begin
                drain_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            timer_q <= '0;
            st_q    <= 1'b0;
            rv_q    <= 1'b0;
            to_q    <= 1'b0;
            drain_q <= 1'b0;
            in0_q   <= '0;
            in1_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= push ? wr_q + PW'(1) : wr_q;
            rd_q    <= pop ? rd_q + PW'(1) : rd_q;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            st_q    <= st_d;
            rv_q    <= rv_d;
            to_q    <= to_d;
            drain_q <= drain_d;
            in0_q   <= in0_d;
            in1_q   <= in1_d;
            data_q  <= data_d;
        end
    end
endmodule

// File: tb/tb_node_invoker.sv
// tb_node_invoker: scoreboard bench for node_invoker driving a behavioural child node (RES = IN0 + IN1).
module tb_node_invoker;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    node_invoker_if #(.WIDTH(W)) bus ();
    node_invoker #(.WIDTH(W), .DEPTH(4), .TIMEOUT(20)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int vectors = 0;
    int miscompares = 0;
    logic [W:0] exp_q[$];

    bit force_low = 1'b0;
    bit hang = 1'b0;
    int low_len = 5;
    logic child_rd, child_busy;
    logic [W-1:0] child_res, ca, cb;
    int ccnt;

    assign bus.ch_rd  = child_rd & ~force_low;
    assign bus.ch_res = child_res;

    // child: sees ST with RD high, drops RD for low_len cycles, then raises RD with the sum
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            child_rd <= 1'b1;
            child_busy <= 1'b0;
            child_res <= '0;
            ccnt <= 0;
        end else if (!child_busy) begin
            if (bus.ch_st && bus.ch_rd && !hang) begin
                child_rd <= 1'b0;
                child_busy <= 1'b1;
                child_res <= 16'hDEAD;
                ca <= bus.ch_in0;
                cb <= bus.ch_in1;
                ccnt <= low_len;
            end
        end else if (ccnt <= 1) begin
            child_rd <= 1'b1;
            child_busy <= 1'b0;
            child_res <= ca + cb;
        end else begin
            ccnt <= ccnt - 1;
        end
    end

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input logic to);
        int n = 0;
        while (!bus.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (bus.req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL push_ready: req_ready=%0b required 1", bus.req_ready);
        end
        bus.req_valid = 1'b1;
        bus.req_a = a;
        bus.req_b = b;
        @(negedge clk);
        bus.req_valid = 1'b0;
        exp_q.push_back(to ? {1'b1, W'(0)} : {1'b0, W'(a + b)});
    endtask

    task automatic get_rsp(output logic [W-1:0] d, output logic t, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.rsp_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        d = bus.rsp_data;
        t = bus.rsp_to;
    endtask

    task automatic accept;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        vectors++;
        if ({bus.rsp_valid, bus.rsp_to, bus.ch_st, bus.busy, bus.req_ready} !== 5'b00001) begin
            miscompares++;
            $display("FAIL reset_ctl: {rv,to,st,busy,rdy}=%b required 00001",
                     {bus.rsp_valid, bus.rsp_to, bus.ch_st, bus.busy, bus.req_ready});
        end
        vectors++;
        if (bus.rsp_data !== '0) begin
            miscompares++;
            $display("FAIL reset_data: rsp_data=%0h required 0", bus.rsp_data);
        end
        vectors++;
        if ({bus.ch_in0, bus.ch_in1} !== '0) begin
            miscompares++;
            $display("FAIL reset_in: in0=%0h in1=%0h required 0 0", bus.ch_in0, bus.ch_in1);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single;
        logic [W-1:0] d;
        logic t;
        bit ok, seen_low, in_bad, st_bad;
        int rise_at, valid_at;
        logic [W:0] e;
        low_len = 5;
        push(3, 4, 0);
        @(negedge clk);
        vectors++;
        if ({bus.ch_st, bus.ch_in0, bus.ch_in1} !== {1'b1, W'(3), W'(4)}) begin
            miscompares++;
            $display("FAIL t1_launch: st=%0b in0=%0d in1=%0d required 1 3 4", bus.ch_st, bus.ch_in0, bus.ch_in1);
        end
        seen_low = 0; in_bad = 0; st_bad = 0; rise_at = -1; valid_at = -1;
        for (int k = 0; k < 100 && valid_at < 0; k++) begin
            if (bus.ch_in0 !== W'(3) || bus.ch_in1 !== W'(4)) in_bad = 1;
            if (bus.rsp_valid === 1'b1) valid_at = k;
            else begin
                if (bus.ch_st !== !seen_low) st_bad = 1;
                if (!bus.ch_rd) seen_low = 1;
                else if (seen_low && rise_at < 0) rise_at = k;
                @(negedge clk);
            end
        end
        vectors++;
        if (in_bad) begin
            miscompares++;
            $display("FAIL t1_in_stable: inputs changed during job, required 3/4 throughout");
        end
        vectors++;
        if (st_bad) begin
            miscompares++;
            $display("FAIL t1_st: ch_st not high exactly until RD fell");
        end
        vectors++;
        if (rise_at < 0 || valid_at !== rise_at + 1) begin
            miscompares++;
            $display("FAIL t1_latency: rsp at %0d rd rise at %0d required rise+1", valid_at, rise_at);
        end
        get_rsp(d, t, ok);
        e = exp_q.pop_front();
        vectors++;
        if (!ok || {t, d} !== e) begin
            miscompares++;
            $display("FAIL t1_rsp: to=%0b data=%0d required to=%0b data=%0d", t, d, e[W], e[W-1:0]);
        end
        accept();
        vectors++;
        if (bus.rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL t1_rsp_drop: rsp_valid=%0b required 0", bus.rsp_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] d;
        logic t;
        bit ok, bad;
        logic [W:0] e;
        low_len = 3;
        force_low = 1'b1;
        @(negedge clk);
        push(0, 1, 0); push(1, 1, 0); push(1, 2, 0); push(2, 2, 0);
        bad = 0;
        repeat (5) begin
            if (bus.req_ready !== 1'b0 || bus.busy !== 1'b1 || bus.ch_st !== 1'b0) bad = 1;
            @(negedge clk);
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL t2_full: req_ready/busy/ch_st wrong while full and child busy, required 0/1/0");
        end
        force_low = 1'b0;
        #1;
        vectors++;
        if (bus.req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL t2_full_pop: req_ready=%0b required 0 on pop cycle", bus.req_ready);
        end
        push(2, 3, 0);
        for (int i = 0; i < 5; i++) begin
            get_rsp(d, t, ok);
            e = exp_q.pop_front();
            vectors++;
            if (!ok || {t, d} !== e) begin
                miscompares++;
                $display("FAIL t2_rsp%0d: to=%0b data=%0d required to=%0b data=%0d", i, t, d, e[W], e[W-1:0]);
            end
            accept();
        end
    endtask

    task automatic test_hold;
        logic [W-1:0] d, d0;
        logic t;
        bit ok, bad;
        logic [W:0] e;
        low_len = 2;
        push(10, 20, 0);
        push(1, 1, 0);
        get_rsp(d, t, ok);
        e = exp_q.pop_front();
        vectors++;
        if (!ok || {t, d} !== e) begin
            miscompares++;
            $display("FAIL t3_rsp: to=%0b data=%0d required to=%0b data=%0d", t, d, e[W], e[W-1:0]);
        end
        d0 = bus.rsp_data;
        bad = 0;
        repeat (10) begin
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== d0 || bus.ch_st !== 1'b0) bad = 1;
            @(negedge clk);
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL t3_hold: response not stable or ch_st raised while RSP_READY=0");
        end
        accept();
        @(negedge clk);
        vectors++;
        if (bus.ch_st !== 1'b1) begin
            miscompares++;
            $display("FAIL t3_next_st: ch_st=%0b required 1 after accept", bus.ch_st);
        end
        get_rsp(d, t, ok);
        e = exp_q.pop_front();
        vectors++;
        if (!ok || {t, d} !== e) begin
            miscompares++;
            $display("FAIL t3_rsp2: to=%0b data=%0d required to=%0b data=%0d", t, d, e[W], e[W-1:0]);
        end
        accept();
    endtask

    task automatic test_timeout;
        logic [W-1:0] d;
        logic t;
        bit ok, bad;
        int n;
        logic [W:0] e;
        hang = 1'b1;
        push(7, 8, 1);
        push(5, 5, 0);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus.rsp_valid === 1'b1) break;
            if (bus.ch_st) n++;
            @(negedge clk);
        end
        vectors++;
        if (n !== 20) begin
            miscompares++;
            $display("FAIL t4_st_cycles: ch_st high %0d cycles required 20", n);
        end
        get_rsp(d, t, ok);
        e = exp_q.pop_front();
        vectors++;
        if (!ok || {t, d} !== e || bus.ch_st !== 1'b0) begin
            miscompares++;
            $display("FAIL t4_rsp: to=%0b data=%0d st=%0b required to=%0b data=%0d st=0",
                     t, d, bus.ch_st, e[W], e[W-1:0]);
        end
        force_low = 1'b1;
        accept();
        bad = 0;
        repeat (5) begin
            if (bus.ch_st !== 1'b0 || bus.busy !== 1'b1) bad = 1;
            @(negedge clk);
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL t4_drain: ch_st raised or busy dropped while draining");
        end
        hang = 1'b0;
        force_low = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.ch_st !== 1'b1) begin
            miscompares++;
            $display("FAIL t4_after_drain: ch_st=%0b required 1", bus.ch_st);
        end
        get_rsp(d, t, ok);
        e = exp_q.pop_front();
        vectors++;
        if (!ok || {t, d} !== e) begin
            miscompares++;
            $display("FAIL t4_rsp2: to=%0b data=%0d required to=%0b data=%0d", t, d, e[W], e[W-1:0]);
        end
        accept();
    endtask

    task automatic test_coincide;
        logic [W-1:0] d;
        logic t;
        bit ok;
        logic [W:0] e;
        for (int i = 0; i < 2; i++) begin
            low_len = 18 + i;
            push(W'(6 + 3 * i), W'(6 + 3 * i), i[0]);
            get_rsp(d, t, ok);
            e = exp_q.pop_front();
            vectors++;
            if (!ok || {t, d} !== e) begin
                miscompares++;
                $display("FAIL t5_len%0d: to=%0b data=%0d required to=%0b data=%0d", low_len, t, d, e[W], e[W-1:0]);
            end
            accept();
        end
    endtask

    task automatic test_reset_mid;
        bit bad;
        low_len = 15;
        push(1, 2, 0); push(3, 3, 0); push(4, 4, 0);
        for (int i = 0; i < 50; i++) begin
            if (!bus.ch_rd && !bus.ch_st) break;
            @(negedge clk);
        end
        #1 rst_n = 1'b0;
        #1;
        exp_q.delete();
        vectors++;
        if ({bus.rsp_valid, bus.rsp_to, bus.ch_st, bus.busy, bus.req_ready} !== 5'b00001 ||
            {bus.rsp_data, bus.ch_in0, bus.ch_in1} !== '0) begin
            miscompares++;
            $display("FAIL t6_async_reset: {rv,to,st,busy,rdy}=%b in0=%0d in1=%0d required 00001 0 0",
                     {bus.rsp_valid, bus.rsp_to, bus.ch_st, bus.busy, bus.req_ready}, bus.ch_in0, bus.ch_in1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0 || bus.ch_st !== 1'b0 || bus.busy !== 1'b0) bad = 1;
        end
        bus.rsp_ready = 1'b0;
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL t6_after_reset: response, start or busy seen after reset, required none");
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_hold();
        test_timeout();
        test_coincide();
        test_reset_mid();
        vectors++;
        if (exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty: %0d expected responses left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
